// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch front end: PC, fetch beat, exception tag and
// the output entry handed to the aligner.
package instr_fetch_pkg;

    typedef logic [31:0] program_counter_t;
    typedef logic [63:0] fetch_data_t;

    typedef enum logic [3:0] {
        EXCEPT_INSTR_MISALIGNED   = 4'd0,
        EXCEPT_INSTR_ACCESS_FAULT = 4'd1
    } except_code_e;

    typedef struct packed {
        logic         valid;
        except_code_e code;
    } except_t;

    typedef struct packed {
        program_counter_t pc;
        fetch_data_t      data;
        except_t          exc;
    } fetch_entry_t;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_e;

    function automatic program_counter_t line_addr(input program_counter_t pc);
        return {pc[31:3], 3'b000};
    endfunction

    // Wraps naturally from 32'hFFFF_FFF8 to 32'h0000_0000.
    function automatic program_counter_t next_line(input program_counter_t pc);
        return {pc[31:3] + 29'd1, 3'b000};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory port: valid/ready request, in-order response without
// backpressure. The fetch unit is the master.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic             req_valid;
    program_counter_t req_addr;
    logic             req_ready;
    logic             resp_valid;
    fetch_data_t      resp_data;
    logic             resp_error;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data, resp_error
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data, resp_error
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO with clear; head is presented combinationally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = i_pop && (cnt_q != '0);
    assign do_push = i_push && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is zeroed on reset so an idle head reads as all-zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !i_clear) begin
            mem_q[wr_q] <= i_data;
        end
    end

    assign o_data  = mem_q[rd_q];
    assign o_count = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch producer: owns the PC, issues line requests under a credit limit,
// buffers responses for the aligner and handles flush and fetch exceptions.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter program_counter_t RESET_PC  = 32'h8000_0000,
    parameter int               BUF_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  program_counter_t     i_redirect_pc,
    instr_fetch_if.master        mem,
    output logic                 o_valid,
    output program_counter_t     o_pc,
    output fetch_data_t          o_data,
    output except_t              o_except
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int EW = $bits(fetch_entry_t);
    localparam int PCW = $bits(program_counter_t);

    fetch_state_e     state_q, state_d;
    program_counter_t pc_q, pc_d;
    logic [CW-1:0]    inflight_q, inflight_d, drop_q, drop_d;
    logic [CW-1:0]    out_count, pc_count;
    logic [CW:0]      credit_used;
    logic             req_valid, accept, mis_push;
    logic             resp_take, err_push, out_push, out_pop, pc_pop;
    program_counter_t resp_pc;
    fetch_entry_t     push_entry, head;

    assign credit_used = {1'b0, inflight_q} + {1'b0, out_count};
    assign accept      = req_valid && mem.req_ready;
    // A response in the flush cycle belongs to the discarded stream.
    assign resp_take   = mem.resp_valid && !i_flush && (drop_q == '0);
    assign err_push    = resp_take && mem.resp_error;
    assign out_push    = resp_take || mis_push;
    assign out_pop     = o_valid && !i_stall;
    assign pc_pop      = resp_take && (pc_count != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_flush)                    state_d = ST_FETCH;
        else if (err_push || mis_push)  state_d = ST_HALT;
    end

    // Request and misaligned-trap decisions; both silenced while in reset.
    always_comb begin
        req_valid = 1'b0;
        mis_push  = 1'b0;
        if (i_rst_n && (state_q == ST_FETCH) && !i_flush) begin
            if (pc_q[1:0] == 2'b00)
                req_valid = credit_used < (CW+1)'(BUF_DEPTH);
            else
                mis_push  = (inflight_q == '0) && (out_count != CW'(BUF_DEPTH));
        end
    end

    assign mem.req_valid = req_valid;
    assign mem.req_addr  = line_addr(pc_q);

    assign inflight_d = inflight_q + CW'(accept) - CW'(mem.resp_valid);

    // Flush or a fault turns every still-outstanding request into a drop.
    always_comb begin
        drop_d = drop_q;
        if (i_flush || err_push)
            drop_d = inflight_d;
        else if (mem.resp_valid && (drop_q != '0))
            drop_d = drop_q - CW'(1);
    end

    always_comb begin
        pc_d = pc_q;
        if (i_flush)     pc_d = i_redirect_pc;
        else if (accept) pc_d = next_line(pc_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        push_entry = '0;
        if (mis_push) begin
            push_entry.pc  = pc_q;
            push_entry.exc = '{valid: 1'b1, code: EXCEPT_INSTR_MISALIGNED};
        end else begin
            push_entry.pc = resp_pc;
            if (mem.resp_error)
                push_entry.exc = '{valid: 1'b1, code: EXCEPT_INSTR_ACCESS_FAULT};
            else
                push_entry.data = mem.resp_data;
        end
    end

    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(EW)) u_out_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_flush),
        .i_push  (out_push),
        .i_data  (push_entry),
        .i_pop   (out_pop),
        .o_data  (head),
        .o_count (out_count)
    );

    // PCs of live requests; dropped requests have already been cleared out.
    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(PCW)) u_pc_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_flush || err_push),
        .i_push  (accept),
        .i_data  (pc_q),
        .i_pop   (pc_pop),
        .o_data  (resp_pc),
        .o_count (pc_count)
    );

    assign o_valid  = (out_count != '0);
    assign o_pc     = head.pc;
    assign o_data   = head.data;
    assign o_except = head.exc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized memory/aligner behaviour checked against a
// stream-level model (expected entries per fetch stream, requests per epoch).
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int               BUF_DEPTH = 2;
    localparam program_counter_t RESET_PC  = 32'h8000_0000;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_stall = 1'b0;
    logic             i_flush = 1'b0;
    program_counter_t i_redirect_pc = '0;
    logic             o_valid;
    program_counter_t o_pc;
    fetch_data_t      o_data;
    except_t          o_except;

    instr_fetch_if mem_if ();

    instr_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .i_redirect_pc (i_redirect_pc),
        .mem           (mem_if),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_data        (o_data),
        .o_except      (o_except)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        program_counter_t addr;
        program_counter_t pc;
        int               epoch;
        int               due;
        int               serial;
    } req_t;

    typedef struct {
        program_counter_t pc;
        fetch_data_t      data;
        except_t          ex;
    } ent_t;

    req_t             memq[$];
    ent_t             expq[$];
    int               epoch = 0, cyc = 0, serial = 0, err_serial = -1, err_pct = 0;
    int               lat_min = 1, lat_max = 1, stall_pct = 0, ready_pct = 100;
    int               checks = 0, passes = 0, fails = 0;
    bit               dead = 1'b0, prev_fl = 1'b0, hold_v = 1'b0;
    program_counter_t next_pc = RESET_PC, hold_pc = '0;
    fetch_data_t      hold_data = '0;

    function automatic fetch_data_t mem_data(input program_counter_t a);
        return {a ^ 32'h5A5A_C3C3, a + 32'h1357_9BDF};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample before posedge, advance the model.
    task automatic tick(input bit fl, input program_counter_t rpc);
        bit rv, err, acc, pop;
        program_counter_t addr;
        req_t r, rr;
        ent_t e;
        i_flush          = fl;
        i_redirect_pc    = rpc;
        i_stall          = ($urandom_range(99) < stall_pct);
        mem_if.req_ready = ($urandom_range(99) < ready_pct);
        rv = (memq.size() != 0) && (memq[0].due <= cyc);
        err = 1'b0;
        mem_if.resp_valid = rv;
        mem_if.resp_error = 1'b0;
        mem_if.resp_data  = '0;
        if (rv) begin
            err = (memq[0].serial == err_serial) || ($urandom_range(99) < err_pct);
            mem_if.resp_error = err;
            mem_if.resp_data  = mem_data(memq[0].addr);
        end
        #1;
        if (prev_fl) chk("o_valid_after_flush", o_valid, 0);
        if (hold_v) begin
            chk("head_held_valid", o_valid, 1);
            chk("head_held_pc", o_pc, hold_pc);
            chk("head_held_data", o_data, hold_data);
        end
        if (o_valid && expq.size() == 0) chk("spurious_o_valid", o_valid, 0);
        if (fl || dead) chk("req_valid_blocked", mem_if.req_valid, 0);
        acc  = mem_if.req_valid && mem_if.req_ready;
        addr = mem_if.req_addr;
        pop  = o_valid && !i_stall && !fl;
        if (pop && expq.size() != 0) begin
            e = expq.pop_front();
            chk("o_pc", o_pc, e.pc);
            chk("o_data", o_data, e.data);
            chk("o_except", o_except, e.ex);
        end
        hold_v    = o_valid && i_stall && !fl;
        hold_pc   = o_pc;
        hold_data = o_data;
        prev_fl   = fl;
        @(posedge i_clk);
        if (rv) rr = memq.pop_front();
        if (acc) begin
            if (!fl && !dead) begin
                chk("req_addr", addr, {next_pc[31:3], 3'b000});
                r.pc    = next_pc;
                r.epoch = epoch;
                next_pc = {next_pc[31:3], 3'b000} + 32'd8;
            end else begin
                r.pc    = '0;
                r.epoch = -1;
            end
            serial++;
            r.addr   = addr;
            r.serial = serial;
            r.due    = cyc + $urandom_range(lat_max, lat_min);
            memq.push_back(r);
            chk("outstanding_le_depth", memq.size() <= BUF_DEPTH, 1);
        end
        if (rv && !fl && rr.epoch == epoch && !dead) begin
            e.pc = rr.pc;
            if (err) begin
                e.data = '0;
                e.ex   = '{valid: 1'b1, code: EXCEPT_INSTR_ACCESS_FAULT};
                dead   = 1'b1;
            end else begin
                e.data = mem_data(rr.addr);
                e.ex   = '0;
            end
            expq.push_back(e);
        end
        if (fl) begin
            epoch++;
            expq.delete();
            next_pc = rpc;
            dead    = 1'b0;
            if (rpc[1:0] != 2'b00) begin
                e.pc   = rpc;
                e.data = '0;
                e.ex   = '{valid: 1'b1, code: EXCEPT_INSTR_MISALIGNED};
                expq.push_back(e);
                dead = 1'b1;
            end
        end
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        mem_if.resp_valid = 1'b0;
        mem_if.resp_error = 1'b0;
        mem_if.req_ready  = 1'b1;
        repeat (n) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_req_valid", mem_if.req_valid, 0);
        chk("rst_o_pc", o_pc, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_except", o_except, 0);
        memq.delete();
        expq.delete();
        epoch++;
        dead    = 1'b0;
        hold_v  = 1'b0;
        prev_fl = 1'b0;
        next_pc = RESET_PC;
        i_rst_n = 1'b1;
        #1;
        chk("first_req_valid", mem_if.req_valid, 1);
        chk("first_req_addr", mem_if.req_addr, RESET_PC);
    endtask

    // Only meaningful once the current stream has halted.
    task automatic drain();
        int n = 0;
        stall_pct = 0;
        ready_pct = 100;
        while ((expq.size() != 0 || memq.size() != 0) && n < 60) begin
            tick(1'b0, '0);
            n++;
        end
        chk("drain_pending_entries", expq.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        program_counter_t rpc;
        mem_if.req_ready  = 1'b1;
        mem_if.resp_valid = 1'b0;
        mem_if.resp_error = 1'b0;
        mem_if.resp_data  = '0;

        // Straight-line fetch, 1-cycle memory.
        do_reset(3);
        run(20);

        // Aligner stall, random memory readiness.
        ready_pct = 60; lat_min = 1; lat_max = 3;
        stall_pct = 100;
        run(5);
        stall_pct = 0; ready_pct = 100;
        run(10);

        // Two requests in flight, then redirect to a mid-line PC.
        lat_min = 5; lat_max = 5;
        n = 0;
        while (memq.size() < 2 && n < 20) begin tick(1'b0, '0); n++; end
        chk("two_in_flight", memq.size(), 2);
        tick(1'b1, 32'h8000_0104);
        lat_min = 1; lat_max = 1;
        run(15);

        // Misaligned redirect halts fetch after one exception entry.
        tick(1'b1, 32'h8000_0102);
        run(12);
        drain();

        // Access fault on the second request of a new stream.
        lat_min = 1; lat_max = 3;
        err_serial = serial + 2;
        tick(1'b1, 32'h8000_2000);
        run(20);
        drain();
        err_serial = -1;

        // Address wrap at the top of the space.
        lat_min = 1; lat_max = 1;
        tick(1'b1, 32'hFFFF_FFF0);
        run(12);

        // Flush coinciding with a response.
        tick(1'b1, 32'h8000_3000);
        n = 0;
        while (!(memq.size() != 0 && memq[0].due <= cyc) && n < 20) begin tick(1'b0, '0); n++; end
        chk("resp_due_at_flush", memq.size() != 0 && memq[0].due <= cyc, 1);
        tick(1'b1, 32'h8000_4000);
        run(10);

        // Randomized traffic with occasional flushes and faults.
        stall_pct = 30; ready_pct = 70; lat_min = 1; lat_max = 4; err_pct = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 4) begin
                case ($urandom_range(9))
                    0: rpc = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00} | 32'h1 | {30'h0, 1'($urandom_range(1)), 1'b0};
                    1: rpc = 32'hFFFF_FFF0;
                    default: rpc = 32'h8000_0000 | {$urandom_range(255, 0), 2'b00};
                endcase
                tick(1'b1, rpc);
            end else begin
                tick(1'b0, '0);
            end
        end
        err_pct = 0;

        // Reset while the output buffer is full and stalled.
        lat_min = 1; lat_max = 1; ready_pct = 100; stall_pct = 100;
        tick(1'b1, 32'h8000_5000);
        run(8);
        do_reset(2);
        stall_pct = 0;
        run(10);
        tick(1'b1, 32'h8000_6001);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
